// File: rtl/ttt_turn_ctrl_if.sv
// Move-request, board-occupancy and board-write signals between the turn
// controller (slave) and the player/board side (master).
interface ttt_turn_ctrl_if;
  logic       start_pulse;
  logic       player1;
  logic [3:0] player1_pos;
  logic       player2;
  logic [3:0] player2_pos;
  logic [8:0] occupied;
  logic [1:0] winner;

  logic       clr_board;
  logic       wr_en;
  logic [3:0] wr_pos;
  logic [1:0] wr_mark;
  logic [1:0] turn;
  logic [3:0] move_count;
  logic       reject;
  logic       timeout;
  logic       game_over;
  logic       draw;

  modport master (
    output start_pulse, player1, player1_pos, player2, player2_pos,
           occupied, winner,
    input  clr_board, wr_en, wr_pos, wr_mark, turn, move_count,
           reject, timeout, game_over, draw
  );

  modport slave (
    input  start_pulse, player1, player1_pos, player2, player2_pos,
           occupied, winner,
    output clr_board, wr_en, wr_pos, wr_mark, turn, move_count,
           reject, timeout, game_over, draw
  );
endinterface

// File: rtl/ttt_turn_ctrl.sv
// Tic-tac-toe turn sequencer: alternates players, validates moves against
// board occupancy, auto-moves on turn timeout and ends on win or full board.
module ttt_turn_ctrl #(
  parameter int unsigned TURN_CYCLES = 1000,
  parameter int unsigned TW          = $clog2(TURN_CYCLES)
) (
  input  logic           clock,
  input  logic           reset,
  ttt_turn_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, TURN, WRITE, CHECK, DONE} state_t;
  typedef enum logic [1:0] {MARK_P1 = 2'b01, MARK_P2 = 2'b10} mark_t;

  localparam logic [TW-1:0] TIMER_LOAD = TW'(TURN_CYCLES - 1);

  state_t        state;
  mark_t         cur_player;
  logic [TW-1:0] timer;

  logic       clr_board;
  logic       wr_en;
  logic [3:0] wr_pos;
  logic [1:0] wr_mark;
  logic [1:0] turn;
  logic [3:0] move_count;
  logic       reject;
  logic       timeout;
  logic       game_over;
  logic       draw;

  logic       act_req;
  logic [3:0] act_pos;
  logic       req_legal;
  logic       free_found;
  logic [3:0] free_idx;
  logic       winner_valid;
  mark_t      next_player;

  // Only the active player's request is examined; out-of-range cells never index occupancy.
  always_comb begin
    act_req      = (cur_player == MARK_P1) ? bus.player1     : bus.player2;
    act_pos      = (cur_player == MARK_P1) ? bus.player1_pos : bus.player2_pos;
    req_legal    = act_req && (act_pos <= 4'd8) && !bus.occupied[act_pos];
    winner_valid = (bus.winner == 2'b01) || (bus.winner == 2'b10);
    next_player  = (cur_player == MARK_P1) ? MARK_P2 : MARK_P1;
  end

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < 9; i++) begin
      if (!free_found && !bus.occupied[4'(i)]) begin
        free_found = 1'b1;
        free_idx   = 4'(i);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cur_player <= MARK_P1;
      timer      <= '0;
      clr_board  <= 1'b0;
      wr_en      <= 1'b0;
      wr_pos     <= '0;
      wr_mark    <= '0;
      turn       <= '0;
      move_count <= '0;
      reject     <= 1'b0;
      timeout    <= 1'b0;
      game_over  <= 1'b0;
      draw       <= 1'b0;
    end else begin
      clr_board <= 1'b0;
      wr_en     <= 1'b0;
      reject    <= 1'b0;
      timeout   <= 1'b0;

      case (state)
        IDLE, DONE: begin
          turn <= '0;
          if (bus.start_pulse) begin
            clr_board  <= 1'b1;
            move_count <= '0;
            game_over  <= 1'b0;
            draw       <= 1'b0;
            cur_player <= MARK_P1;
            timer      <= TIMER_LOAD;
            turn       <= MARK_P1;
            state      <= TURN;
          end
        end

        TURN: begin
          // A legal request beats the timeout; an illegal one at timer=0 just times out.
          if (req_legal) begin
            wr_pos  <= act_pos;
            wr_mark <= cur_player;
            wr_en   <= 1'b1;
            turn    <= '0;
            state   <= WRITE;
          end else if (timer == '0) begin
            turn <= '0;
            if (free_found) begin
              wr_pos  <= free_idx;
              wr_mark <= cur_player;
              wr_en   <= 1'b1;
              timeout <= 1'b1;
              state   <= WRITE;
            end else begin
              game_over <= 1'b1;
              draw      <= 1'b1;
              state     <= DONE;
            end
          end else begin
            timer  <= timer - 1'b1;
            reject <= act_req;
          end
        end

        WRITE: begin
          move_count <= move_count + 4'd1;
          state      <= CHECK;
        end

        CHECK: begin
          if (winner_valid) begin
            game_over <= 1'b1;
            draw      <= 1'b0;
            state     <= DONE;
          end else if (move_count == 4'd9) begin
            game_over <= 1'b1;
            draw      <= 1'b1;
            state     <= DONE;
          end else begin
            cur_player <= next_player;
            turn       <= next_player;
            timer      <= TIMER_LOAD;
            state      <= TURN;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.clr_board  = clr_board;
  assign bus.wr_en      = wr_en;
  assign bus.wr_pos     = wr_pos;
  assign bus.wr_mark    = wr_mark;
  assign bus.turn       = turn;
  assign bus.move_count = move_count;
  assign bus.reject     = reject;
  assign bus.timeout    = timeout;
  assign bus.game_over  = game_over;
  assign bus.draw       = draw;

endmodule

// File: tb/tb_ttt_turn_ctrl.sv
// Scoreboard bench for ttt_turn_ctrl: a board-level game model predicts
// write/reject/clear/end-of-game events that a separate monitor checks.
module tb_ttt_turn_ctrl;

  localparam int TC = 20;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ttt_turn_ctrl_if bus ();

  ttt_turn_ctrl #(.TURN_CYCLES(TC)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef enum int {K_CLR, K_REJ, K_WR, K_DONE} kind_t;
  typedef struct {
    kind_t kind;
    int    pos;
    int    mark;
    int    flag;
    int    cnt;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  // Game model: board[i] is 0 empty, 1 P1, 2 P2
  int board[9];
  int cur, moves, tleft;
  bit over;
  bit noise;
  bit prev_go;
  int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                      '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input kind_t k, input int pos, input int mark, input int flag, input int cnt);
    ev_t e;
    e.kind = k; e.pos = pos; e.mark = mark; e.flag = flag; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic take(input kind_t k);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got %s expected none at %0t", k.name(), $time);
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", k, e.kind);
    if (k != e.kind) return;
    case (k)
      K_WR: begin
        check("wr_pos", bus.wr_pos, e.pos);
        check("wr_mark", bus.wr_mark, e.mark);
        check("wr_timeout", bus.timeout, e.flag);
      end
      K_DONE: begin
        check("done_draw", bus.draw, e.flag);
        check("done_move_count", bus.move_count, e.cnt);
        check("done_turn", bus.turn, 0);
      end
      default: ;
    endcase
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event
  initial begin
    prev_go = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) prev_go = 1'b0;
      else begin
        if (bus.clr_board) take(K_CLR);
        if (bus.reject) take(K_REJ);
        if (bus.wr_en) take(K_WR);
        if (bus.timeout) check("timeout_with_wr_en", bus.wr_en, 1);
        if (bus.game_over && !prev_go) take(K_DONE);
        prev_go = bus.game_over;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic int win_of();
    for (int l = 0; l < 8; l++) begin
      if (board[lines[l][0]] != 0 && board[lines[l][0]] == board[lines[l][1]] &&
          board[lines[l][0]] == board[lines[l][2]])
        return board[lines[l][0]];
    end
    return 0;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_board();
    logic [8:0] occ;
    int w;
    for (int i = 0; i < 9; i++) occ[i] = (board[i] != 0);
    bus.occupied = occ;
    w = win_of();
    if (w == 1) bus.winner = 2'b01;
    else if (w == 2) bus.winner = 2'b10;
    else bus.winner = (noise && $urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
  endtask

  task automatic clear_reqs();
    bus.player1 = 1'b0;
    bus.player2 = 1'b0;
  endtask

  task automatic do_start();
    bus.start_pulse = 1'b1;
    push(K_CLR, 0, 0, 0, 0);
    tick();
    bus.start_pulse = 1'b0;
    for (int i = 0; i < 9; i++) board[i] = 0;
    cur = 1; moves = 0; tleft = TC - 1; over = 0;
    drive_board();
  endtask

  task automatic check_turn_state();
    check("turn", bus.turn, (cur == 1) ? 1 : 2);
    check("move_count", bus.move_count, moves);
    check("game_over_in_play", bus.game_over, 0);
  endtask

  task automatic do_move(input int pos, input int to);
    int w;
    push(K_WR, pos, cur, to, 0);
    tick();
    clear_reqs();
    board[pos] = cur;
    drive_board();
    tick();
    moves++;
    w = win_of();
    if (w != 0) begin
      push(K_DONE, 0, 0, 0, moves);
      over = 1;
    end else if (moves == 9) begin
      push(K_DONE, 0, 0, 1, 9);
      over = 1;
    end else begin
      cur = 3 - cur;
      tleft = TC - 1;
    end
    tick();
  endtask

  task automatic turn_cycle(input bit r1, input int p1, input bit r2, input int p2, output bit moved);
    bit ar;
    int ap, f;
    check_turn_state();
    bus.player1 = r1; bus.player1_pos = 4'(p1);
    bus.player2 = r2; bus.player2_pos = 4'(p2);
    ar = (cur == 1) ? r1 : r2;
    ap = (cur == 1) ? p1 : p2;
    moved = 0;
    if (ar && ap < 9 && board[ap] == 0) begin
      do_move(ap, 0);
      moved = 1;
    end else if (tleft == 0) begin
      f = -1;
      for (int i = 8; i >= 0; i--) if (board[i] == 0) f = i;
      if (f >= 0) do_move(f, 1);
      else begin
        push(K_DONE, 0, 0, 1, moves);
        over = 1;
        tick();
      end
      moved = 1;
    end else begin
      if (ar) push(K_REJ, 0, 0, 0, 0);
      tleft--;
      tick();
    end
    clear_reqs();
  endtask

  function automatic int rand_pos();
    return ($urandom_range(0, 7) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
  endfunction

  task automatic play_random();
    bit lazy, moved, r1, r2;
    while (!over) begin
      lazy  = ($urandom_range(0, 7) == 0);
      moved = 0;
      while (!moved) begin
        r1 = ($urandom_range(0, 2) == 0);
        r2 = ($urandom_range(0, 2) == 0);
        if (lazy && cur == 1) r1 = 0;
        if (lazy && cur == 2) r2 = 0;
        turn_cycle(r1, rand_pos(), r2, rand_pos(), moved);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_clr_board"}, bus.clr_board, 0);
    check({tag, "_wr_en"}, bus.wr_en, 0);
    check({tag, "_wr_pos"}, bus.wr_pos, 0);
    check({tag, "_wr_mark"}, bus.wr_mark, 0);
    check({tag, "_turn"}, bus.turn, 0);
    check({tag, "_move_count"}, bus.move_count, 0);
    check({tag, "_reject"}, bus.reject, 0);
    check({tag, "_timeout"}, bus.timeout, 0);
    check({tag, "_game_over"}, bus.game_over, 0);
    check({tag, "_draw"}, bus.draw, 0);
  endtask

  int seq_c[5] = '{0, 1, 3, 2, 6};
  int seq_d[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

  initial begin
    bit mv;
    bus.start_pulse = 1'b0;
    bus.player1 = 1'b0; bus.player1_pos = '0;
    bus.player2 = 1'b0; bus.player2_pos = '0;
    bus.occupied = '0;  bus.winner = '0;
    noise = 0;
    reset = 1'b1;
    tick(); tick(); tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();
    check("idle_turn", bus.turn, 0);

    // Game A: legal move, rejects, ignored opponent, then reset mid-turn
    do_start();
    turn_cycle(1, 4, 0, 0, mv);
    turn_cycle(0, 0, 1, 4, mv);
    turn_cycle(0, 0, 1, 9, mv);
    turn_cycle(0, 0, 1, 1, mv);
    turn_cycle(0, 0, 1, 0, mv);
    turn_cycle(0, 0, 1, 0, mv);
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    check("queue_empty_at_reset", exp_q.size(), 0);
    exp_q.delete();
    tick(); tick();
    reset = 1'b0;
    tick();

    // Game B: cells 0 and 1 taken, P1 idle until timeout places at cell 2
    do_start();
    turn_cycle(1, 0, 0, 0, mv);
    turn_cycle(0, 0, 1, 1, mv);
    mv = 0;
    while (!mv) turn_cycle(0, 0, 0, 0, mv);
    play_random();

    // Game C: P1 wins on column 0 after five moves, then restart
    do_start();
    for (int i = 0; i < 5; i++) begin
      if (cur == 1) turn_cycle(1, seq_c[i], 0, 0, mv);
      else turn_cycle(0, 0, 1, seq_c[i], mv);
    end
    check("win_over", over, 1);
    do_start();
    check_turn_state();
    check("restart_draw", bus.draw, 0);
    play_random();

    // Game D: full board without a winner
    do_start();
    for (int i = 0; i < 9; i++) begin
      if (cur == 1) turn_cycle(1, seq_d[i], 0, 0, mv);
      else turn_cycle(0, 0, 1, seq_d[i], mv);
    end

    for (int g = 0; g < 25; g++) begin
      noise = (g % 2 == 1);
      do_start();
      play_random();
    end

    tick(); tick();
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ttt_turn_ctrl.md
Name: ttt_turn_ctrl

Overview:
Turn sequencer and move arbiter for the tic-tac-toe board datapath. It alternates control between player 1 and player 2, validates each requested cell against board occupancy, and issues single-cycle write strobes to the board register file. It enforces a per-turn timeout, auto-placing a mark in the lowest free cell when the timeout expires. It ends the game on a win reported by the win checker or after 9 moves.

Parameters:
TURN_CYCLES, 1000, cycles allowed per turn before the auto-move; must be ≥2.
TW, $clog2(TURN_CYCLES), width of the turn timer.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; forces IDLE
start_pulse  in  1  starts a new game from IDLE or DONE; ignored otherwise
player1  in  1  P1 move request (level; sampled each cycle)
player1_pos  in  4  P1 requested cell, 0..8
player2  in  1  P2 move request
player2_pos  in  4  P2 requested cell, 0..8
occupied  in  9  board occupancy; bit i=1 means cell i is taken
winner  in  2  from win checker: 00 none, 01 P1, 10 P2, 11 illegal (treated as none)
clr_board  out  1  one-cycle pulse: board clear
wr_en  out  1  one-cycle board write strobe
wr_pos  out  4  cell to write; valid while wr_en=1
wr_mark  out  2  01 P1, 10 P2; valid while wr_en=1
turn  out  2  01 P1 to move, 10 P2 to move, 00 no turn active
move_count  out  4  moves written this game, 0..9
reject  out  1  one-cycle pulse: request by the active player was illegal
timeout  out  1  one-cycle pulse: auto-move taken
game_over  out  1  high in DONE
draw  out  1  high in DONE when no winner

Behaviour:
- Reset (async): state=IDLE, timer=0. All outputs are 0: clr_board, wr_en, wr_pos, wr_mark, turn, move_count, reject, timeout, game_over, draw.
- States: IDLE, TURN, WRITE, CHECK, DONE. A registered cur_player (01/10) is kept alongside the state.
- IDLE/DONE: turn=00. On start_pulse: clr_board=1 for the next cycle, move_count←0, game_over←0, draw←0, cur_player←01, timer←TURN_CYCLES-1, go to TURN.
- TURN: turn=cur_player. Only the active player's request/pos are examined; the other player's inputs are ignored and produce no reject.
  - Request with pos≤8 and occupied[pos]=0: latch wr_pos=pos and wr_mark=cur_player, then go to WRITE.
  - Request with pos>8 or an occupied cell: reject=1 for that cycle and stay in TURN; the timer keeps running.
  - No legal request and timer=0: wr_pos←lowest index i with occupied[i]=0, timeout=1 for one cycle, go to WRITE.
  - No legal request and timer=0 with no free cell (defensive case): go to DONE with draw=1.
  - Otherwise timer decrements.
  - A legal request in the timer=0 cycle takes priority over the timeout.
- WRITE: wr_en=1 for exactly one cycle; move_count increments; go to CHECK.
- CHECK: the board and win checker reflect the write this cycle.
  - winner∈{01,10}: go to DONE with game_over=1, draw=0.
  - Else if move_count=9: go to DONE with game_over=1, draw=1.
  - Else: cur_player toggles, timer←TURN_CYCLES-1, go to TURN.
- Latency: legal request sampled at edge k → wr_en high in cycle k+1 → CHECK in cycle k+2 → next player's turn from cycle k+3.
- start_pulse in TURN, WRITE, or CHECK: ignored.
- winner input is ignored outside CHECK.
- wr_pos and wr_mark hold their last value when wr_en=0.
- Reset asserted mid-game: returns to IDLE immediately. The board is cleared only via clr_board or its own reset.

Test Plan (TURN_CYCLES=20):
1. Reset, start_pulse; P1 requests pos 4 → clr_board pulse; wr_en one cycle later with wr_pos=4, wr_mark=01; turn=10 three cycles after the request; move_count=1.
2. In P2's turn, P2 requests pos 4 (occupied) → reject pulse, turn stays 10. Then pos 9 → reject pulse. Then pos 1 → wr_en with wr_pos=1, wr_mark=10.
3. In P1's turn, player2=1 with pos 0 → no write and no reject; turn stays 01.
4. Occupied=000000011 (cells 0 and 1 taken), P1 idle for 20 cycles → timeout pulse; wr_pos=2, wr_mark=01.
5. P1 plays 0, 3, 6 while P2 plays 1, 2; winner=01 in the CHECK after the 5th move → game_over=1, draw=0, turn=00, move_count=5. A following start_pulse clears game_over and move_count and sets turn=01.
6. Full game with no winner → after the 9th write, game_over=1, draw=1, move_count=9. Reset asserted mid-turn → all outputs 0 immediately.
